wallace_mul_seq: RTL and testbench
==================================

# wallace_mul_seq

Multi-cycle, parametrised X·Y unsigned multiplier for the large-number datapath. Each cycle it multiplies the full XW-bit X by one DW-bit digit of Y through a Wallace CSA tree. It folds the result into a running accumulator, so arbitrary-width operands cost YW/DW cycles instead of a YW-row tree. It sits between the operand loader and the result writer, with valid/ready handshakes on both sides.

## Interface
- XW, 1024, width of multiplicand X.
- YW, 1024, width of multiplier Y; must be a multiple of DW.
- DW, 8, digit width consumed per cycle (rows in the CSA tree); 2 ≤ DW ≤ 32.
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- in_valid  in  1  operands X, Y valid.
- in_ready  out  1  block can accept operands (high only in IDLE).
- X  in  XW  multiplicand, unsigned.
- Y  in  YW  multiplier, unsigned.
- out_valid  out  1  P holds a finished product.
- out_ready  in  1  consumer accepts P.
- P  out  XW+YW  product X·Y, unsigned.
- busy  out  1  high in CALC.

## Operation
- NDIG = YW/DW.
- States:
  - IDLE: in_ready=1. in_valid&in_ready captures X and Y into internal registers, clears the accumulator and digit counter, and goes to CALC.
  - CALC: one digit per cycle, least significant first. acc += (X·Y[k·DW +: DW]) << (k·DW). After the last digit, goes to HOLD.
  - HOLD: out_valid=1, P stable. out_valid&out_ready goes to IDLE.
- Per-digit product is formed as DW AND-gated rows of X, reduced by a 3:2 CSA tree, together with the accumulator window, to sum/carry vectors. A single carry-propagate add per cycle resolves them. The accumulator is binary at every clock edge; no carry-save state persists across cycles.
- Width rule: result is exact modulo 2^(XW+YW), and never overflows. Intermediate sums are held at XW+DW+1 bits minimum.
- X and Y inputs are ignored outside the accept cycle; changing them during CALC has no effect.
- in_valid during CALC/HOLD is not accepted (in_ready=0); the producer holds it.
- No back-to-back accept in the HOLD→IDLE cycle: the earliest next accept is the cycle after leaving HOLD.
- Reset asserted mid-CALC or mid-HOLD:
  - State goes to IDLE immediately.
  - The product is discarded.
  - No out_valid pulse follows.

## Timing
- Reset values:
  - State IDLE, in_ready=1, out_valid=0, busy=0, P=0.
  - Accumulator, digit counter and operand registers are 0.
- Latency: accept on edge t causes out_valid to rise after edge t+NDIG, i.e. NDIG CALC cycles (128 at defaults). This holds unless the early-done feature is compiled in.
- P is registered and changes only on the edge entering HOLD; it holds its value through IDLE until the next product completes.
- Throughput: one product per NDIG+2 cycles with out_ready held high.
- Critical path per cycle: CSA tree depth for DW+1 rows plus one (XW+DW+1)-bit CPA.

## Configuration
- WALLACE_MUL_EARLY_DONE_EN
  - Defined: CALC exits to HOLD as soon as all remaining unprocessed Y digits are zero, checked after each digit. The minimum is one CALC cycle: Y=0 gives out_valid after edge t+1, and Y=1 gives out_valid after edge t+1. P is identical to the full-latency result.
  - Undefined: CALC always runs exactly NDIG cycles, regardless of Y.

## Test plan
- Reset: hold rst_n=0 with random inputs → in_ready=1, out_valid=0, busy=0, P=0. Deassert, then X=3, Y=5 → P=15 after NDIG cycles.
- Small config XW=16, YW=16, DW=4, X=16'hFFFF, Y=16'hFFFF → P=32'hFFFE0001. out_valid rises exactly 4 cycles after accept (macro off).
- Default widths, X=2^1024−1, Y=2^1024−1 → P=2^2048−2^1025+1. Also X=0 → P=0. Random pairs are checked against a reference model over 200 products.
- Backpressure: hold out_ready=0 for 10 cycles in HOLD → P stable, out_valid stays 1, and in_ready=0 with in_valid=1 and no capture. Release → product taken, next operands accepted one cycle later.
- Reset mid-CALC: assert rst_n=0 at CALC cycle 3 → outputs take their reset values asynchronously, and no out_valid appears afterwards. A fresh X=7, Y=9 → P=63.
- Macro on, XW=YW=16, DW=4: Y=16'h0003 → out_valid 1 cycle after accept, P=3·X. Y=16'h1000 → 4 cycles. Y=0 → 1 cycle, P=0.

Source files
------------

// File: rtl/wallace_mul_seq.sv
// rtl/wallace_mul_seq.sv - digit-serial unsigned multiplier with Wallace CSA tree per digit
//
// Computes P = X * Y by taking one DW-bit digit of Y per cycle, least
// significant first. Each cycle the DW partial-product rows of X and the
// current accumulator window are reduced by a 3:2 CSA tree to two vectors.
// A single carry-propagate add then writes the window back, so the
// accumulator holds a plain binary value at every clock edge.
//
// Optional feature macro: WALLACE_MUL_EARLY_DONE_EN
//   When this macro is defined, CALC ends as soon as the remaining Y digits
//   are all zero. When it is undefined, CALC always runs YW/DW cycles.
//
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   operands X, Y valid
//   in_ready   operands accepted this cycle when in_valid is high (IDLE only)
//   X          multiplicand, XW bits, unsigned
//   Y          multiplier, YW bits, unsigned
//   out_valid  P holds a finished product (HOLD)
//   out_ready  consumer accepts P
//   P          product X*Y, XW+YW bits, registered
//   busy       high while digits are being processed (CALC)

module wallace_mul_seq #(
    parameter int XW = 1024,
    parameter int YW = 1024,
    parameter int DW = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XW-1:0]    X,
    input  logic [YW-1:0]    Y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XW+YW-1:0] P,
    output logic             busy
);

    localparam int NDIG = YW / DW;
    localparam int KW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    // Window width: X times one digit plus the accumulator's upper part
    // stays below 2^(XW+DW); one extra bit keeps the sum safe.
    localparam int WW   = XW + DW + 1;
    localparam int NR   = DW + 1;
    // One spare bit on top so the window at the last digit stays in range.
    localparam int ACCW = XW + YW + 1;
    localparam int PW   = XW + YW;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_HOLD
    } state_t;

    state_t          state, state_nxt;
    logic [XW-1:0]   x_q;
    logic [YW-1:0]   y_q;       // shifted right one digit per CALC cycle
    logic [ACCW-1:0] acc_q;
    logic [ACCW-1:0] acc_nxt;
    logic [KW-1:0]   k_q;
    logic [PW-1:0]   p_q;

    logic [DW-1:0]   digit;
    logic [YW-1:0]   y_rest;
    logic [WW-1:0]   sum_vec;
    logic [WW-1:0]   carry_vec;
    logic [WW-1:0]   cpa;
    logic            last_digit;

    assign digit  = y_q[DW-1:0];
    assign y_rest = y_q >> DW;

`ifdef WALLACE_MUL_EARLY_DONE_EN
    assign last_digit = (k_q == KW'(NDIG - 1)) || (y_rest == '0);
`else
    assign last_digit = (k_q == KW'(NDIG - 1));
`endif

    // Wallace reduction: each level groups rows in threes through full
    // adders (two rows out), passing leftovers through, until two remain.
    always_comb begin : csa_tree
        logic [WW-1:0] rows [NR];
        logic [WW-1:0] tmp  [NR];
        int            base;
        int            n;
        int            m;

        base = int'(k_q) * DW;
        for (int i = 0; i < DW; i++) begin
            rows[i] = digit[i] ? (WW'(x_q) << i) : '0;
        end
        rows[DW] = acc_q[base +: WW];
        n = NR;
        m = 0;
        for (int lvl = 0; lvl < NR; lvl++) begin
            if (n > 2) begin
                for (int j = 0; j < NR; j++) begin
                    tmp[j] = '0;
                end
                m = 0;
                for (int j = 0; j + 2 < NR; j += 3) begin
                    if (j + 2 < n) begin
                        tmp[m]     = rows[j] ^ rows[j+1] ^ rows[j+2];
                        tmp[m + 1] = ((rows[j] & rows[j+1]) |
                                      (rows[j] & rows[j+2]) |
                                      (rows[j+1] & rows[j+2])) << 1;
                        m = m + 2;
                    end
                end
                for (int j = 0; j < NR; j++) begin
                    if (j >= (n / 3) * 3 && j < n) begin
                        tmp[m] = rows[j];
                        m = m + 1;
                    end
                end
                rows = tmp;
                n = m;
            end
        end
        sum_vec   = rows[0];
        carry_vec = rows[1];

        cpa     = sum_vec + carry_vec;
        acc_nxt = acc_q;
        acc_nxt[base +: WW] = cpa;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (in_valid)   state_nxt = S_CALC;
            S_CALC: if (last_digit) state_nxt = S_HOLD;
            S_HOLD: if (out_ready)  state_nxt = S_IDLE;
            default:                state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            x_q   <= '0;
            y_q   <= '0;
            acc_q <= '0;
            k_q   <= '0;
            p_q   <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        x_q   <= X;
                        y_q   <= Y;
                        acc_q <= '0;
                        k_q   <= '0;
                    end
                end
                S_CALC: begin
                    acc_q <= acc_nxt;
                    y_q   <= y_rest;
                    k_q   <= k_q + KW'(1);
                    if (last_digit) begin
                        p_q <= acc_nxt[PW-1:0];
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign in_ready  = (state == S_IDLE);
    assign busy      = (state == S_CALC);
    assign out_valid = (state == S_HOLD);
    assign P         = p_q;

endmodule

// File: tb/tb_wallace_mul_seq.sv
// tb/tb_wallace_mul_seq.sv - directed and reference-model bench for wallace_mul_seq

module tb_wallace_mul_seq;

    localparam int BXW = 1024;
    localparam int BYW = 1024;
    localparam int BDW = 8;
    localparam int BND = BYW / BDW;
    localparam int SXW = 16;
    localparam int SYW = 16;
    localparam int SDW = 4;
    localparam int SND = SYW / SDW;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic                 b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_busy;
    logic [BXW-1:0]       b_X;
    logic [BYW-1:0]       b_Y;
    logic [BXW+BYW-1:0]   b_P;

    logic                 s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_busy;
    logic [SXW-1:0]       s_X;
    logic [SYW-1:0]       s_Y;
    logic [SXW+SYW-1:0]   s_P;

    wallace_mul_seq #(.XW(BXW), .YW(BYW), .DW(BDW)) u_big (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready),
        .X(b_X), .Y(b_Y),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .P(b_P), .busy(b_busy)
    );

    wallace_mul_seq #(.XW(SXW), .YW(SYW), .DW(SDW)) u_small (
        .clk(clk), .rst_n(rst_n),
        .in_valid(s_in_valid), .in_ready(s_in_ready),
        .X(s_X), .Y(s_Y),
        .out_valid(s_out_valid), .out_ready(s_out_ready),
        .P(s_P), .busy(s_busy)
    );

    int checks = 0;
    int errors = 0;

    logic [2047:0] b_model;
    bit            b_pending = 1'b0;
    logic [31:0]   s_model;
    bit            s_pending = 1'b0;

    task automatic chk(input string name, input logic [2047:0] act, input logic [2047:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (low 128 bits)", name, act[127:0], exp[127:0]);
        end
    endtask

    function automatic logic [1023:0] rand1024();
        logic [1023:0] r;
        for (int i = 0; i < 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Cycles from accept to out_valid: every digit, or only up to the
    // highest non-zero digit when early exit is compiled in.
    function automatic int lat_of(input logic [1023:0] y, input int nd, input int dw);
        int l;
`ifdef WALLACE_MUL_EARLY_DONE_EN
        l = 1;
        for (int k = 0; k < nd; k++) if ((y >> (k * dw)) != 0) l = k + 1;
`else
        l = nd;
`endif
        return l;
    endfunction

    // Per-cycle comparison against the model whenever a product is shown.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("big_ready_vs_state", b_in_ready, !(b_busy || b_out_valid));
            chk("small_ready_vs_state", s_in_ready, !(s_busy || s_out_valid));
            if (b_out_valid) begin
                chk("big_valid_has_job", b_pending, 1);
                chk("big_p", b_P, b_model);
            end
            if (s_out_valid) begin
                chk("small_valid_has_job", s_pending, 1);
                chk("small_p", s_P, s_model);
            end
        end
    end

    task automatic run_big(input logic [1023:0] x, input logic [1023:0] y, input int hold,
                           input bit pres, input logic [1023:0] nx, input logic [1023:0] ny);
        int cnt;
        int lat;
        @(negedge clk);
        chk("big_ready_before_accept", b_in_ready, 1);
        b_X = x; b_Y = y; b_in_valid = 1'b1; b_out_ready = 1'b0;
        b_model = {1024'b0, x} * {1024'b0, y};
        b_pending = 1'b1;
        lat = lat_of(y, BND, BDW);
        @(posedge clk); #1;
        b_in_valid = 1'b0; b_X = rand1024(); b_Y = rand1024();
        cnt = 0;
        while (!b_out_valid && cnt < 2 * BND + 8) begin
            @(posedge clk); #1;
            cnt++;
        end
        chk("big_latency", cnt, lat);
        if (pres) begin
            b_X = nx; b_Y = ny; b_in_valid = 1'b1;
        end
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk("big_hold_valid", b_out_valid, 1);
            chk("big_hold_no_accept", b_in_ready, 0);
        end
        b_out_ready = 1'b1;
        @(posedge clk); #1;
        b_out_ready = 1'b0;
        b_pending = 1'b0;
        chk("big_released", b_out_valid, 0);
        chk("big_idle_ready", b_in_ready, 1);
        chk("big_no_b2b", b_busy, 0);
    endtask

    task automatic run_small(input logic [15:0] x, input logic [15:0] y);
        int cnt;
        int lat;
        @(negedge clk);
        chk("small_ready_before_accept", s_in_ready, 1);
        s_X = x; s_Y = y; s_in_valid = 1'b1; s_out_ready = 1'b0;
        s_model = {16'b0, x} * {16'b0, y};
        s_pending = 1'b1;
        lat = lat_of({1008'b0, y}, SND, SDW);
        @(posedge clk); #1;
        s_in_valid = 1'b0; s_X = 16'($urandom); s_Y = 16'($urandom);
        cnt = 0;
        while (!s_out_valid && cnt < 2 * SND + 8) begin
            @(posedge clk); #1;
            cnt++;
        end
        chk("small_latency", cnt, lat);
        s_out_ready = 1'b1;
        @(posedge clk); #1;
        s_out_ready = 1'b0;
        s_pending = 1'b0;
        chk("small_released", s_out_valid, 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2047:0] all_ones_sq;
        logic [1023:0] ones;
        logic [1023:0] bx, by;

        rst_n = 1'b0;
        b_out_ready = 1'b0; s_out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            b_in_valid = 1'b1; b_X = rand1024(); b_Y = rand1024();
            s_in_valid = 1'b1; s_X = 16'($urandom); s_Y = 16'($urandom);
            @(negedge clk);
            chk("rst_big_in_ready", b_in_ready, 1);
            chk("rst_big_out_valid", b_out_valid, 0);
            chk("rst_big_busy", b_busy, 0);
            chk("rst_big_p", b_P, 0);
            chk("rst_small_in_ready", s_in_ready, 1);
            chk("rst_small_out_valid", s_out_valid, 0);
            chk("rst_small_p", s_P, 0);
        end
        b_in_valid = 1'b0; s_in_valid = 1'b0;
        rst_n = 1'b1;

        run_big(1024'd3, 1024'd5, 0, 0, '0, '0);
        chk("big_3x5", b_P, 2048'd15);

        run_small(16'hFFFF, 16'hFFFF);
        chk("small_ffff_sq", s_P, 32'hFFFE0001);
        run_small(16'h1234, 16'h0003);
        chk("small_y3", s_P, 32'h0000369C);
        run_small(16'hABCD, 16'h1000);
        chk("small_y1000", s_P, 32'h0ABCD000);
        run_small(16'hBEEF, 16'h0000);
        chk("small_y0", s_P, 32'h0);

        ones = '1;
        all_ones_sq = '0;
        all_ones_sq[0] = 1'b1;
        for (int i = 1025; i < 2048; i++) all_ones_sq[i] = 1'b1;
        run_big(ones, ones, 0, 0, '0, '0);
        chk("big_all_ones", b_P, all_ones_sq);

        run_big('0, rand1024(), 0, 0, '0, '0);
        chk("big_x0", b_P, 2048'd0);

        // Backpressure: next operands presented during HOLD, taken after release.
        bx = rand1024(); by = rand1024();
        run_big(rand1024(), rand1024(), 10, 1, bx, by);
        run_big(bx, by, 0, 0, '0, '0);

        // Reset in the middle of CALC.
        @(negedge clk);
        b_X = rand1024(); b_Y = rand1024(); b_in_valid = 1'b1;
        @(posedge clk); #1;
        b_in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        b_pending = 1'b0;
        #1;
        chk("midrst_in_ready", b_in_ready, 1);
        chk("midrst_out_valid", b_out_valid, 0);
        chk("midrst_busy", b_busy, 0);
        chk("midrst_p", b_P, 0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        b_out_ready = 1'b1;
        repeat (BND + 5) @(posedge clk);
        b_out_ready = 1'b0;
        run_big(1024'd7, 1024'd9, 0, 0, '0, '0);
        chk("big_7x9", b_P, 2048'd63);

        for (int t = 0; t < 200; t++) begin
            bx = rand1024(); by = rand1024();
            if (t % 4 == 1) bx = bx >> ($urandom_range(0, 1000));
            if (t % 4 == 2) by = by >> ($urandom_range(0, 1000));
            run_big(bx, by, t % 3, 0, '0, '0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
